// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle req/ack CDC handshake blocks.
package cdc_pkg;

  typedef enum logic [1:0] {HS_IDLE, HS_SETUP, HS_WAIT} hs_tx_state_e;

  localparam int HS_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2dff.sv
// Two-flop level synchroniser with an optional simulation-only glitch monitor
// that flags an input toggling back before the first toggle reached the output.
module sync_2dff
  import cdc_pkg::*;
#(
  parameter int SYNTHESIS             = 0,
  parameter int ENABLE_GLITCH_MONITOR = 0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o,
  output logic glitch_o
);

  logic [HS_SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) ff <= '0;
    else         ff <= {ff[HS_SYNC_STAGES-2:0], d_i};
  end

  assign q_o = ff[HS_SYNC_STAGES-1];

  generate
    if (ENABLE_GLITCH_MONITOR != 0 && SYNTHESIS == 0) begin : g_mon
      logic glitch;
      // Stage 0 already differs from the output and the input has moved again.
      always_ff @(posedge clk_i) begin
        if (!rstn_i)                              glitch <= 1'b0;
        else if ((ff[0] != ff[1]) && (d_i != ff[0])) glitch <= 1'b1;
      end
      assign glitch_o = glitch;
    end else begin : g_nomon
      assign glitch_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cdc_hs_tx.sv
// Transmit side of a two-phase toggle req/ack CDC handshake: capture, settle,
// toggle req, then wait for the synchronised ack toggle before the next word.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int TIMEOUT_CYCLES        = 0,
  parameter int SYNTHESIS             = 0,
  parameter int ENABLE_GLITCH_MONITOR = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  req_o,
  input  logic                  ack_i,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic                  proto_err_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);

  hs_tx_state_e          state, state_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  req_n, done_n, timeout_n, ready_n, proto_n;
  logic                  ack_s, ack_prev, glitch;

  sync_2dff #(
    .SYNTHESIS            (SYNTHESIS),
    .ENABLE_GLITCH_MONITOR(ENABLE_GLITCH_MONITOR)
  ) u_ack_sync (
    .clk_i   (clk_i),
    .rstn_i  (~rst_i),
    .d_i     (ack_i),
    .q_o     (ack_s),
    .glitch_o(glitch)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= HS_IDLE;
      data_o      <= '0;
      req_o       <= 1'b0;
      cnt         <= '0;
      ack_prev    <= 1'b0;
      ready_o     <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      data_o      <= data_n;
      req_o       <= req_n;
      cnt         <= cnt_n;
      ack_prev    <= ack_s;
      ready_o     <= ready_n;
      done_o      <= done_n;
      timeout_o   <= timeout_n;
      proto_err_o <= proto_n;
    end
  end

  always_comb begin
    state_n   = state;
    data_n    = data_o;
    req_n     = req_o;
    cnt_n     = cnt;
    done_n    = 1'b0;
    timeout_n = 1'b0;
    case (state)
      HS_IDLE: begin
        if (valid_i && ready_o) begin
          data_n  = data_i;
          state_n = HS_SETUP;
        end
      end
      HS_SETUP: begin
        req_n   = ~req_o;
        cnt_n   = '0;
        state_n = HS_WAIT;
      end
      HS_WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (ack_s == req_o) begin
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = HS_IDLE;
        end else begin
          if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) timeout_n = 1'b1;
          if (cnt != TO_MAX) cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = HS_IDLE;
    endcase
    ready_n = (state_n == HS_IDLE);
    proto_n = proto_err_o | glitch | ((ack_s != ack_prev) && (state != HS_WAIT));
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx with a randomised destination ack model.
module tb_cdc_hs_tx;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        ready_o, req_o, ack_i, done_o, timeout_o, proto_err_o;
  logic [31:0] data_o;

  int compared = 0, mismatched = 0;

  // Destination model: manual ack level, or automatic echo of req_o after a random delay.
  logic auto_ack = 1'b0, man_ack = 1'b0, auto_val = 1'b0;
  int   dly_cnt = 0, ack_dly = 2;
  assign ack_i = auto_ack ? auto_val : man_ack;

  always #5 clk = ~clk;

  cdc_hs_tx #(
    .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .SYNTHESIS(0), .ENABLE_GLITCH_MONITOR(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .data_o(data_o), .req_o(req_o), .ack_i(ack_i),
    .done_o(done_o), .timeout_o(timeout_o), .proto_err_o(proto_err_o)
  );

  always @(negedge clk) begin
    if (!auto_ack) begin
      auto_val <= man_ack;
      dly_cnt  <= 0;
    end else if (req_o != auto_val) begin
      if (dly_cnt >= ack_dly) begin
        auto_val <= req_o;
        dly_cnt  <= 0;
        ack_dly  <= $urandom_range(0, 6);
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if ({ready_o, req_o, done_o, timeout_o, proto_err_o} !== 5'b0) begin
      mismatched++; $display("FAIL reset_ctrl: got %b want 00000", {ready_o, req_o, done_o, timeout_o, proto_err_o}); end
    compared++; if (data_o !== 32'h0) begin mismatched++; $display("FAIL reset_data: got %h want 0", data_o); end
    step();
    compared++; if (ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_single();
    do_reset(); step();
    data_i = 32'hDEAD_BEEF; valid_i = 1'b1;
    step();
    valid_i = 1'b0; data_i = $urandom;
    compared++; if (data_o !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL single_data: got %h want deadbeef", data_o); end
    compared++; if ({req_o, ready_o} !== 2'b00) begin mismatched++; $display("FAIL single_setup: got req/ready %b want 00", {req_o, ready_o}); end
    step();
    compared++; if (req_o !== 1'b1) begin mismatched++; $display("FAIL single_req: got %b want 1", req_o); end
    repeat (4) step();
    man_ack = 1'b1;
    step(); step();
    compared++; if (done_o !== 1'b0) begin mismatched++; $display("FAIL single_done_early: got %b want 0", done_o); end
    step();
    compared++; if ({done_o, ready_o} !== 2'b11) begin mismatched++; $display("FAIL single_done: got done/ready %b want 11", {done_o, ready_o}); end
    step();
    compared++; if ({done_o, proto_err_o} !== 2'b00) begin mismatched++; $display("FAIL single_after: got done/perr %b want 00", {done_o, proto_err_o}); end
    compared++; if (data_o !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL single_hold: got %h want deadbeef", data_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] held = '0, w;
    logic        prev_req = 1'b0, waiting = 1'b0, acc;
    int          sent = 0, toggles = 0, dones = 0;
    do_reset(); step();
    auto_ack = 1'b1; valid_i = 1'b1; data_i = 32'd0;
    for (int c = 0; c < 600 && dones < 8; c++) begin
      acc = valid_i && ready_o;
      step();
      if (acc) begin
        exp_q.push_back(data_i); sent++;
        if (sent == 8) valid_i = 1'b0; else data_i = sent;
      end
      if (req_o !== prev_req) begin
        prev_req = req_o; toggles++;
        compared++;
        if (exp_q.size() == 0) begin mismatched++; $display("FAIL b2b_extra_req: toggle %0d without accepted word", toggles); end
        else begin
          w = exp_q.pop_front();
          if (data_o !== w) begin mismatched++; $display("FAIL b2b_word: got %h want %h", data_o, w); end
        end
        held = data_o; waiting = 1'b1;
      end else if (waiting) begin
        compared++; if (data_o !== held) begin mismatched++; $display("FAIL b2b_hold: got %h want %h", data_o, held); end
      end
      if (done_o === 1'b1) begin dones++; waiting = 1'b0; end
    end
    compared++; if (toggles != 8) begin mismatched++; $display("FAIL b2b_toggles: got %0d want 8", toggles); end
    compared++; if (dones != 8) begin mismatched++; $display("FAIL b2b_dones: got %0d want 8", dones); end
    compared++; if (req_o !== 1'b0) begin mismatched++; $display("FAIL b2b_final_req: got %b want 0", req_o); end
    man_ack = auto_val; auto_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] w;
    logic        prev_req, prev_ack, acc, exp_done;
    logic [1:0]  pend = 2'b00;
    int          sent = 0, dones = 0;
    do_reset(); step();
    prev_req = req_o; prev_ack = ack_i;
    auto_ack = 1'b1; data_i = $urandom; valid_i = 1'b1;
    for (int c = 0; c < 3000 && dones < 20; c++) begin
      acc = valid_i && ready_o;
      step();
      if (acc) begin exp_q.push_back(data_i); sent++; data_i = $urandom; end
      valid_i = (sent < 20) && ($urandom_range(0, 3) != 0);
      if (req_o !== prev_req) begin
        prev_req = req_o;
        compared++;
        if (exp_q.size() == 0) begin mismatched++; $display("FAIL rnd_extra_req: toggle without accepted word"); end
        else begin
          w = exp_q.pop_front();
          if (data_o !== w) begin mismatched++; $display("FAIL rnd_word: got %h want %h", data_o, w); end
        end
      end
      // done_o follows an ack edge by exactly two more samples (two sync flops + output flop).
      exp_done = pend[1];
      pend = {pend[0], (ack_i !== prev_ack)};
      prev_ack = ack_i;
      compared++; if (done_o !== exp_done) begin mismatched++; $display("FAIL rnd_done: got %b want %b", done_o, exp_done); end
      if (done_o === 1'b1) dones++;
    end
    compared++; if (dones != 20) begin mismatched++; $display("FAIL rnd_count: got %0d want 20", dones); end
    compared++; if ({timeout_o, proto_err_o} !== 2'b00) begin mismatched++; $display("FAIL rnd_flags: got %b want 00", {timeout_o, proto_err_o}); end
    valid_i = 1'b0; man_ack = auto_val; auto_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int first = -1, pulses = 0, n = 0;
    do_reset(); step();
    data_i = $urandom; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    while (req_o !== 1'b1 && n < 10) begin step(); n++; end
    compared++; if (req_o !== 1'b1) begin mismatched++; $display("FAIL to_req: got %b want 1 within 10 cycles", req_o); end
    for (int i = 1; i <= 40; i++) begin
      step();
      if (timeout_o === 1'b1) begin pulses++; if (first < 0) first = i; end
    end
    compared++; if (first != 16) begin mismatched++; $display("FAIL to_delay: got %0d want 16", first); end
    compared++; if (pulses != 1) begin mismatched++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    compared++; if (ready_o !== 1'b0) begin mismatched++; $display("FAIL to_wait: got ready %b want 0", ready_o); end
    man_ack = 1'b1;
    step(); step(); step();
    compared++; if ({done_o, ready_o, timeout_o} !== 3'b110) begin
      mismatched++; $display("FAIL to_late_ack: got done/ready/to %b want 110", {done_o, ready_o, timeout_o}); end
  endtask

  task automatic test_proto_err();
    do_reset(); step();
    man_ack = 1'b1;
    step(); step();
    compared++; if (proto_err_o !== 1'b0) begin mismatched++; $display("FAIL perr_early: got %b want 0", proto_err_o); end
    step();
    compared++; if (proto_err_o !== 1'b1) begin mismatched++; $display("FAIL perr_set: got %b want 1", proto_err_o); end
    repeat (5) step();
    compared++; if ({proto_err_o, ready_o, req_o} !== 3'b110) begin
      mismatched++; $display("FAIL perr_sticky: got perr/ready/req %b want 110", {proto_err_o, ready_o, req_o}); end
    do_reset();
    compared++; if (proto_err_o !== 1'b0) begin mismatched++; $display("FAIL perr_clear: got %b want 0", proto_err_o); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] w;
    int n = 0;
    do_reset(); step();
    data_i = $urandom | 32'h1; valid_i = 1'b1;
    step(); valid_i = 1'b0;
    step();
    compared++; if (req_o !== 1'b1) begin mismatched++; $display("FAIL rmw_req: got %b want 1", req_o); end
    repeat (3) step();
    rst_i = 1'b1; man_ack = 1'b0;
    step();
    compared++; if ({req_o, ready_o} !== 2'b00 || data_o !== 32'h0) begin
      mismatched++; $display("FAIL rmw_reset: got req/ready %b data %h want 00 / 0", {req_o, ready_o}, data_o); end
    rst_i = 1'b0;
    step();
    compared++; if (ready_o !== 1'b1) begin mismatched++; $display("FAIL rmw_ready: got %b want 1", ready_o); end
    w = $urandom; data_i = w; valid_i = 1'b1;
    step(); valid_i = 1'b0;
    step();
    man_ack = 1'b1;
    while (done_o !== 1'b1 && n < 10) begin step(); n++; end
    compared++; if (done_o !== 1'b1) begin mismatched++; $display("FAIL rmw_done: got %b want 1 within 10 cycles", done_o); end
    compared++; if (data_o !== w || proto_err_o !== 1'b0) begin
      mismatched++; $display("FAIL rmw_clean: got data %h perr %b want %h / 0", data_o, proto_err_o, w); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_timeout();
    test_proto_err();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
